// File: rtl/fib_ctrl.sv
// Control FSM in front of the calc Fibonacci datapath: sequences clear/seed/iterate
// and captures F(n) from calc, flagging indices that would overflow the result width.
module fib_ctrl #(
   parameter int N_W    = 5,
   parameter int DATA_W = 20,
   parameter int MAX_N  = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_W-1:0]    n,
   input  logic [DATA_W-1:0] result_in,
   output logic              ready,
   output logic              rst_ctl,
   output logic              mux,
   output logic              en,
   output logic [DATA_W-1:0] fib_out,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_STEP,
      S_CAPTURE
   } state_t;

   state_t            r_state;
   logic [N_W-1:0]    r_cnt;
   logic [N_W-1:0]    r_nQ;
   logic [DATA_W-1:0] r_fibOut;
   logic              r_done;
   logic              r_err;
   logic              r_ready;
   logic              r_rstCtl;
   logic              r_mux;
   logic              r_en;
   logic              w_nLegal;

   assign w_nLegal = (n <= N_W'(MAX_N));

   // Control outputs are set alongside each transition so they always match the
   // decode of the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_nQ     <= '0;
         r_fibOut <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_ready  <= 1'b1;
         r_rstCtl <= 1'b0;
         r_mux    <= 1'b0;
         r_en     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_nLegal) begin
                     r_nQ     <= n;
                     r_err    <= 1'b0;
                     r_state  <= S_CLEAR;
                     r_ready  <= 1'b0;
                     r_rstCtl <= 1'b1;
                  end else begin
                     r_done   <= 1'b1;
                     r_err    <= 1'b1;
                     r_fibOut <= '0;
                  end
               end
            end
            S_CLEAR: begin
               r_rstCtl <= 1'b0;
               if (r_nQ == '0) begin
                  r_state <= S_CAPTURE;
               end else begin
                  r_state <= S_LOAD;
                  r_en    <= 1'b1;
                  r_mux   <= 1'b1;
               end
            end
            S_LOAD: begin
               r_mux <= 1'b0;
               if (r_nQ <= N_W'(2)) begin
                  r_state <= S_CAPTURE;
                  r_en    <= 1'b0;
               end else begin
                  r_cnt   <= r_nQ - N_W'(2);
                  r_state <= S_STEP;
               end
            end
            S_STEP: begin
               r_cnt <= r_cnt - N_W'(1);
               if (r_cnt == N_W'(1)) begin
                  r_state <= S_CAPTURE;
                  r_en    <= 1'b0;
               end
            end
            S_CAPTURE: begin
               r_fibOut <= result_in;
               r_done   <= 1'b1;
               r_ready  <= 1'b1;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state  <= S_IDLE;
               r_ready  <= 1'b1;
               r_rstCtl <= 1'b0;
               r_mux    <= 1'b0;
               r_en     <= 1'b0;
            end
         endcase
      end
   end

   assign ready   = r_ready;
   assign rst_ctl = r_rstCtl;
   assign mux     = r_mux;
   assign en      = r_en;
   assign fib_out = r_fibOut;
   assign done    = r_done;
   assign err     = r_err;

endmodule

// File: tb/tb_fib_ctrl.sv
// Bench pairing fib_ctrl with a behavioural calc datapath; directed runs with
// hand-computed Fibonacci values and cycle latencies.
module tb_fib_ctrl;

   localparam int N_W    = 5;
   localparam int DATA_W = 20;

   logic              clk;
   logic              rst;
   logic              start;
   logic [N_W-1:0]    n;
   logic [DATA_W-1:0] resultIn;
   logic              ready;
   logic              rstCtl;
   logic              mux;
   logic              en;
   logic [DATA_W-1:0] fibOut;
   logic              done;
   logic              err;

   logic [DATA_W-1:0] fn1;
   logic [DATA_W-1:0] fn2;

   int checks = 0;
   int errors = 0;

   fib_ctrl #(.N_W(N_W), .DATA_W(DATA_W), .MAX_N(30)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n         (n),
      .result_in (resultIn),
      .ready     (ready),
      .rst_ctl   (rstCtl),
      .mux       (mux),
      .en        (en),
      .fib_out   (fibOut),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural calc: Fn1/Fn2 registers with a combinational sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fn1 <= '0;
         fn2 <= '0;
      end else if (rstCtl) begin
         fn1 <= '0;
         fn2 <= '0;
      end else if (en) begin
         if (mux) begin
            fn1 <= 20'd1;
            fn2 <= 20'd0;
         end else begin
            fn1 <= fn1 + fn2;
            fn2 <= fn1;
         end
      end
   end
   assign resultIn = fn1 + fn2;

   // Issues a start from a negedge; cycle 0 is the cycle the start is presented in.
   task automatic launch(input logic [N_W-1:0] nv);
      start = 1'b1;
      n     = nv;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts negedges after the launch until done, noting any calc controls seen.
   task automatic waitDone(output int cyc, output bit timedOut, output bit sawEn, output bit sawRst);
      cyc      = 0;
      timedOut = 1'b1;
      sawEn    = 1'b0;
      sawRst   = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (en) sawEn = 1'b1;
         if (rstCtl) sawRst = 1'b1;
         if (done) begin
            cyc      = i;
            timedOut = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      n     = '0;
      #12;
      checks++;
      if ({ready, rstCtl, mux, en, done, err} !== 6'b100000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got %b want 100000", {ready, rstCtl, mux, en, done, err});
      end
      checks++;
      if (fibOut !== 20'd0) begin
         errors++;
         $display("[TB] FAIL reset_fib got %0d want 0", fibOut);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [N_W-1:0]    nTab   [5] = '{5'd0, 5'd1, 5'd2, 5'd10, 5'd30};
      int                latTab [5] = '{3, 4, 4, 12, 32};
      logic [DATA_W-1:0] fibTab [5] = '{20'd0, 20'd1, 20'd1, 20'd55, 20'd832040};
      int cyc;
      bit timedOut, sawEn, sawRst;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_ready n=%0d got %b want 1", nTab[k], ready);
         end
         launch(nTab[k]);
         waitDone(cyc, timedOut, sawEn, sawRst);
         checks++;
         if (timedOut || cyc != latTab[k]) begin
            errors++;
            $display("[TB] FAIL basic_latency n=%0d got %0d (timeout %0b) want %0d", nTab[k], cyc, timedOut, latTab[k]);
         end
         checks++;
         if (fibOut !== fibTab[k] || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_result n=%0d got %0d err %b want %0d err 0", nTab[k], fibOut, err, fibTab[k]);
         end
         if (nTab[k] == 5'd0) begin
            checks++;
            if (sawEn !== 1'b0 || sawRst !== 1'b1) begin
               errors++;
               $display("[TB] FAIL n0_controls got en %b rst_ctl %b want en 0 rst_ctl 1", sawEn, sawRst);
            end
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || fibOut !== fibTab[k]) begin
            errors++;
            $display("[TB] FAIL basic_pulse n=%0d got done %b fib %0d want done 0 fib %0d", nTab[k], done, fibOut, fibTab[k]);
         end
      end
   endtask

   task automatic test_error();
      int cyc;
      bit timedOut, sawEn, sawRst;
      launch(5'd31);
      waitDone(cyc, timedOut, sawEn, sawRst);
      checks++;
      if (timedOut || cyc != 1 || err !== 1'b1 || fibOut !== 20'd0) begin
         errors++;
         $display("[TB] FAIL err_done got cyc %0d err %b fib %0d want cyc 1 err 1 fib 0", cyc, err, fibOut);
      end
      checks++;
      if (sawEn || sawRst || ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_controls got en %b rst_ctl %b ready %b want 0 0 1", sawEn, sawRst, ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_hold got done %b err %b want done 0 err 1", done, err);
      end
   endtask

   task automatic test_ignored_start();
      int cyc = 0;
      bit seenDone = 1'b0;
      launch(5'd20);
      for (int i = 1; i <= 60 && !seenDone; i++) begin
         @(negedge clk);
         if (done) begin
            cyc      = i;
            seenDone = 1'b1;
         end else if (i == 5 || i == 10) begin
            start = 1'b1;
            n     = 5'd3;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      checks++;
      if (!seenDone || cyc != 22 || fibOut !== 20'd6765 || err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ignored_start got cyc %0d fib %0d err %b want cyc 22 fib 6765 err 0", cyc, fibOut, err);
      end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      int cyc;
      bit timedOut, sawEn, sawRst;
      bit sawDone = 1'b0;
      launch(5'd25);
      for (int i = 1; i <= 8; i++) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({ready, rstCtl, mux, en, done} !== 5'b10000 || fibOut !== 20'd0) begin
         errors++;
         $display("[TB] FAIL midreset_state got ctrl %b fib %0d want 10000 fib 0", {ready, rstCtl, mux, en, done}, fibOut);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) sawDone = 1'b1;
      end
      checks++;
      if (sawDone) begin
         errors++;
         $display("[TB] FAIL midreset_nodone got done seen 1 want 0");
      end
      launch(5'd5);
      waitDone(cyc, timedOut, sawEn, sawRst);
      checks++;
      if (timedOut || cyc != 7 || fibOut !== 20'd5) begin
         errors++;
         $display("[TB] FAIL midreset_rerun got cyc %0d fib %0d want cyc 7 fib 5", cyc, fibOut);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit timedOut, sawEn, sawRst;
      launch(5'd7);
      waitDone(cyc, timedOut, sawEn, sawRst);
      checks++;
      if (timedOut || cyc != 9 || fibOut !== 20'd13 || ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_first got cyc %0d fib %0d ready %b want cyc 9 fib 13 ready 1", cyc, fibOut, ready);
      end
      launch(5'd8);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_accept got done %b ready %b want done 0 ready 0", done, ready);
      end
      waitDone(cyc, timedOut, sawEn, sawRst);
      checks++;
      if (timedOut || cyc != 9 || fibOut !== 20'd21) begin
         errors++;
         $display("[TB] FAIL b2b_second got cyc %0d fib %0d want cyc 9 (10 from start) fib 21", cyc, fibOut);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_pulse got done %b want 0", done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error();
      test_ignored_start();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
